// File: rtl/watchdog_supervisor.sv
// Arms the watchdog, debounces match/timeout, retries, issues one pass/fail verdict; no backpressure.
// Latency: start -> timer_en after 1+CLEAR_CYCLES cycles; qualified match -> done after 1 cycle.
module watchdog_supervisor #(
  parameter int MAX_RETRIES  = 3,
  parameter int CLEAR_CYCLES = 16,
  parameter int MATCH_HOLD   = 4,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_match_event,
  input  logic             i_timeout_event,
  output logic             o_wd_rst,
  output logic             o_timer_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_fail,
  output logic [1:0]       o_attempt,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt
);

  localparam int AW = $clog2(MAX_RETRIES + 1) + 1;
  localparam int CW = $clog2(CLEAR_CYCLES);
  localparam int MW = $clog2(MATCH_HOLD + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_RETRY   = 3'd3;
  localparam logic [2:0] S_VERDICT = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] clr_cnt;
  logic [MW-1:0] match_cnt;
  logic [AW-1:0] attempt, attempt_nxt;
  logic [AW+1:0] attempt_wide;
  logic          start_ok;

  assign start_ok     = (state == S_IDLE) && i_start && !i_abort;
  assign attempt_wide = {2'b00, attempt_nxt};

  always_comb begin
    state_nxt   = state;
    attempt_nxt = attempt;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt   = S_CLEAR;
          attempt_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == CW'(CLEAR_CYCLES - 1)) state_nxt = S_ARM;
      end
      S_ARM: begin
        // A completing match beats a timeout seen in the same cycle.
        if (i_match_event && (match_cnt == MW'(MATCH_HOLD - 1))) state_nxt = S_VERDICT;
        else if (i_timeout_event)                                state_nxt = S_RETRY;
      end
      S_RETRY: begin
        if (attempt < AW'(MAX_RETRIES)) begin
          state_nxt   = S_CLEAR;
          attempt_nxt = attempt + AW'(1);
        end else begin
          state_nxt = S_VERDICT;
        end
      end
      S_VERDICT: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (i_abort && (state != S_IDLE)) begin
      state_nxt   = S_IDLE;
      attempt_nxt = attempt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      match_cnt  <= '0;
      attempt    <= '0;
      o_wd_rst   <= 1'b1;
      o_timer_en <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
      o_fail     <= 1'b0;
      o_attempt  <= 2'd0;
      o_pass_cnt <= '0;
      o_fail_cnt <= '0;
    end else begin
      state      <= state_nxt;
      attempt    <= attempt_nxt;
      clr_cnt    <= (state == S_CLEAR) ? clr_cnt + CW'(1) : '0;
      match_cnt  <= ((state == S_ARM) && i_match_event) ? match_cnt + MW'(1) : '0;
      // Outputs are decoded from the next state so they line up with the state register.
      o_wd_rst   <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
      o_timer_en <= (state_nxt == S_ARM);
      o_busy     <= (state_nxt != S_IDLE);
      o_done     <= (state_nxt == S_VERDICT);
      o_attempt  <= (attempt_wide > (AW+2)'(3)) ? 2'd3 : attempt_wide[1:0];
      if (start_ok) begin
        o_pass <= 1'b0;
        o_fail <= 1'b0;
      end
      if (state_nxt == S_VERDICT) begin
        if (state == S_ARM) begin
          o_pass <= 1'b1;
          if (o_pass_cnt != '1) o_pass_cnt <= o_pass_cnt + CNT_W'(1);
        end else begin
          o_fail <= 1'b1;
          if (o_fail_cnt != '1) o_fail_cnt <= o_fail_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Scoreboarded bench for watchdog_supervisor: verdicts queued at stimulus time, checked on o_done.
module tb_watchdog_supervisor;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n, start, abort_req, match_ev, timeout_ev;
  logic wd_rst, timer_en, busy, done, pass, fail;
  logic [1:0] attempt;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  typedef struct packed {
    int p;
    int f;
    int att;
    int pc;
    int fc;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_pass = 0;
  int   m_fail = 0;
  int   n, n2, c, g;

  always #5 clk = ~clk;

  watchdog_supervisor #(
    .MAX_RETRIES(3), .CLEAR_CYCLES(16), .MATCH_HOLD(4), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort_req),
    .i_match_event(match_ev), .i_timeout_event(timeout_ev),
    .o_wd_rst(wd_rst), .o_timer_en(timer_en), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_fail(fail), .o_attempt(attempt),
    .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_arm(output int cycles);
    cycles = 0;
    while (!timer_en && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic push_pass(input int att);
    m_pass = (m_pass < 3) ? m_pass + 1 : 3;
    sb.push_back('{p: 1, f: 0, att: att, pc: m_pass, fc: m_fail});
  endtask

  task automatic push_fail(input int att);
    m_fail = (m_fail < 3) ? m_fail + 1 : 3;
    sb.push_back('{p: 0, f: 1, att: att, pc: m_pass, fc: m_fail});
  endtask

  task automatic match_pass(input string tag);
    match_ev = 1'b1;
    repeat (4) tick();
    match_ev = 1'b0;
    check(tag, done, 1);
  endtask

  // Verdict monitor: every o_done cycle must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        got_e = sb.pop_front();
        check("sb_pass", pass, got_e.p);
        check("sb_fail", fail, got_e.f);
        check("sb_attempt", attempt, got_e.att);
        check("sb_pass_cnt", pass_cnt, got_e.pc);
        check("sb_fail_cnt", fail_cnt, got_e.fc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort_req = 1'b0; match_ev = 1'b0; timeout_ev = 1'b0;
    #23;
    check("rst_wd_rst", wd_rst, 1);
    check("rst_timer_en", timer_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnts", {pass, fail, attempt, pass_cnt, fail_cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // First-attempt match
    start_pulse();
    check("busy_after_start", busy, 1);
    check("wd_rst_in_clear", wd_rst, 1);
    wait_arm(n);
    check("arm_latency", 1 + n, 17);
    check("wd_rst_in_arm", wd_rst, 0);
    push_pass(0);
    match_pass("done_latency");
    tick();
    check("idle_after_pass", busy, 0);

    // Glitch followed by four timeouts
    start_pulse();
    wait_arm(n);
    match_ev = 1'b1;
    repeat (3) tick();
    match_ev = 1'b0;
    tick();
    check("glitch_no_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push_fail(3);
      timeout_ev = 1'b1;
      tick();
      timeout_ev = 1'b0;
      check("retry_timer_off", timer_en, 0);
      if (k < 3) begin
        c = 0;
        g = 0;
        do begin
          tick();
          g++;
          if (wd_rst) c++;
        end while (!timer_en && g < 200);
        check("clear_len", c, 16);
        check("attempt_idx", attempt, k + 1);
      end else begin
        tick();
        check("fail_done", done, 1);
      end
    end
    tick();

    // Match completes on the same cycle as a timeout
    start_pulse();
    wait_arm(n);
    push_pass(0);
    match_ev = 1'b1;
    repeat (3) tick();
    timeout_ev = 1'b1;
    tick();
    match_ev = 1'b0;
    timeout_ev = 1'b0;
    check("simul_done", done, 1);
    tick();

    // Abort during CLEAR, with a start that must be ignored
    start_pulse();
    repeat (4) tick();
    abort_req = 1'b1;
    start = 1'b1;
    tick();
    abort_req = 1'b0;
    start = 1'b0;
    check("abort_clr_busy", busy, 0);
    check("abort_clr_wd_rst", wd_rst, 1);
    check("abort_clr_pass", pass, 0);
    repeat (25) tick();
    check("abort_clr_idle", busy, 0);

    // Abort during ARM
    start_pulse();
    wait_arm(n);
    match_ev = 1'b1;
    repeat (2) tick();
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    match_ev = 1'b0;
    check("abort_arm_busy", busy, 0);
    check("abort_arm_timer", timer_en, 0);
    check("abort_arm_fail", fail, 0);
    check("abort_pass_cnt", pass_cnt, m_pass);
    check("abort_fail_cnt", fail_cnt, m_fail);
    repeat (3) tick();

    // Start while busy does not restart the sequence
    start_pulse();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_arm(n2);
    check("busy_start_latency", 1 + 5 + 1 + n2, 17);
    push_pass(0);
    match_pass("busy_start_done");
    tick();

    // Abort and start together in IDLE
    abort_req = 1'b1;
    start = 1'b1;
    tick();
    abort_req = 1'b0;
    start = 1'b0;
    check("idle_abort_start", busy, 0);

    // Stale timeout held through CLEAR
    timeout_ev = 1'b1;
    start_pulse();
    wait_arm(n);
    timeout_ev = 1'b0;
    check("stale_latency", 1 + n, 17);
    tick();
    check("stale_no_retry", timer_en, 1);
    push_pass(0);
    match_pass("stale_done");
    tick();

    // Fifth pass: tally pinned at its 2-bit ceiling
    start_pulse();
    wait_arm(n);
    push_pass(0);
    match_pass("sat_done");
    tick();
    check("sat_pass_cnt", pass_cnt, 3);
    check("fail_cnt_final", fail_cnt, 1);

    // Asynchronous reset in the middle of ARM
    start_pulse();
    wait_arm(n);
    match_ev = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("async_wd_rst", wd_rst, 1);
    check("async_timer_en", timer_en, 0);
    check("async_busy", busy, 0);
    check("async_pass_cnt", pass_cnt, 0);
    check("async_fail_cnt", fail_cnt, 0);
    check("async_attempt", attempt, 0);
    match_ev = 1'b0;
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
